// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the icache/dcache memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IC,
        BUSY_DC,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_IC,
        REQ_DC
    } requester_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_LINE_W  = 128;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache line transfers onto the single memory port,
// alternating on contention and bounding every access with a timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              mem_timeout
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t        r_state, w_state;
    requester_t        r_last, w_last;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_mem_req, w_mem_req;
    logic              r_mem_we, w_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
    logic [LINE_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_ic_ack, w_ic_ack;
    logic              r_dc_ack, w_dc_ack;
    logic [LINE_W-1:0] r_ic_rdata, w_ic_rdata;
    logic [LINE_W-1:0] r_dc_rdata, w_dc_rdata;
    logic              r_timeout, w_timeout;
    logic              w_pick_dc;
    logic              w_done;
    logic [LINE_W-1:0] w_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= REQ_IC;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ic_ack    <= 1'b0;
            r_dc_ack    <= 1'b0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_last      <= w_last;
            r_cnt       <= w_cnt;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_ic_ack    <= w_ic_ack;
            r_dc_ack    <= w_dc_ack;
            r_ic_rdata  <= w_ic_rdata;
            r_dc_rdata  <= w_dc_rdata;
            r_timeout   <= w_timeout;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_last      = r_last;
        w_cnt       = r_cnt;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_ic_ack    = 1'b0;
        w_dc_ack    = 1'b0;
        w_ic_rdata  = r_ic_rdata;
        w_dc_rdata  = r_dc_rdata;
        w_timeout   = r_timeout;
        // On contention the side that did not win last time goes first.
        w_pick_dc   = dc_req && (!ic_req || (r_last == REQ_IC));
        // mem_ready takes priority over an expiring wait counter.
        w_done      = mem_ready || (r_cnt == CNT_MAX);
        w_line      = mem_ready ? mem_rdata : '0;

        unique case (r_state)
            IDLE: begin
                if (ic_req || dc_req) begin
                    w_mem_req = 1'b1;
                    w_cnt     = '0;
                    if (w_pick_dc) begin
                        w_state     = BUSY_DC;
                        w_last      = REQ_DC;
                        w_mem_we    = dc_we;
                        w_mem_addr  = dc_addr;
                        w_mem_wdata = dc_wdata;
                    end else begin
                        w_state     = BUSY_IC;
                        w_last      = REQ_IC;
                        w_mem_we    = 1'b0;
                        w_mem_addr  = ic_addr;
                        w_mem_wdata = '0;
                    end
                end
            end
            BUSY_IC, BUSY_DC: begin
                if (w_done) begin
                    w_state   = RESP;
                    w_mem_req = 1'b0;
                    if (!mem_ready) begin
                        w_timeout = 1'b1;
                    end
                    if (r_state == BUSY_IC) begin
                        w_ic_ack   = 1'b1;
                        w_ic_rdata = w_line;
                    end else begin
                        w_dc_ack = 1'b1;
                        if (!r_mem_we) begin
                            w_dc_rdata = w_line;
                        end
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign ic_ack      = r_ic_ack;
    assign dc_ack      = r_dc_ack;
    assign ic_rdata    = r_ic_rdata;
    assign dc_rdata    = r_dc_rdata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_ack;
    logic [LW-1:0] ic_rdata;
    logic          dc_req;
    logic          dc_we;
    logic [AW-1:0] dc_addr;
    logic [LW-1:0] dc_wdata;
    logic          dc_ack;
    logic [LW-1:0] dc_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ready;
    logic [LW-1:0] mem_rdata;
    logic          mem_timeout;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ack(dc_ack), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit            is_dc;
        bit            we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int unsigned   delay;
        logic [LW-1:0] rdata;
        logic [LW-1:0] exp_ic;
        logic [LW-1:0] exp_dc;
    } vec_t;

    vec_t vecs[5];

    localparam logic [LW-1:0] A5S  = {16{8'hA5}};
    localparam logic [LW-1:0] L77  = {16{8'h77}};
    localparam logic [LW-1:0] L012 = {4{32'h01234567}};
    localparam logic [LW-1:0] LCAF = {4{32'hCAFEF00D}};

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ic_req    = 1'b0;
        ic_addr   = '0;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        dc_addr   = '0;
        dc_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One complete transaction from IDLE; memory answers after v.delay wait cycles.
    task automatic run_vec(input vec_t v, input int idx, input bit exp_to);
        ic_req    = !v.is_dc;
        ic_addr   = v.is_dc ? '0 : v.addr;
        dc_req    = v.is_dc;
        dc_we     = v.we;
        dc_addr   = v.is_dc ? v.addr : '0;
        dc_wdata  = v.wdata;
        mem_ready = 1'b0;
        tick();
        chk($sformatf("v%0d mem_req", idx), mem_req, 1);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
        chk($sformatf("v%0d mem_we", idx), mem_we, v.is_dc && v.we);
        if (v.is_dc) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        for (int unsigned i = 0; i < v.delay; i++) begin
            mem_ready = 1'b0;
            mem_rdata = ~v.rdata;
            tick();
            chk($sformatf("v%0d wait mem_req", idx), mem_req, 1);
            chk($sformatf("v%0d wait acks", idx), {ic_ack, dc_ack}, 0);
        end
        mem_ready = 1'b1;
        mem_rdata = v.rdata;
        tick();
        chk($sformatf("v%0d done mem_req", idx), mem_req, 0);
        chk($sformatf("v%0d ic_ack", idx), ic_ack, !v.is_dc);
        chk($sformatf("v%0d dc_ack", idx), dc_ack, v.is_dc);
        chk($sformatf("v%0d ic_rdata", idx), ic_rdata, v.exp_ic);
        chk($sformatf("v%0d dc_rdata", idx), dc_rdata, v.exp_dc);
        chk($sformatf("v%0d mem_timeout", idx), mem_timeout, exp_to);
        ic_req    = 1'b0;
        dc_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk($sformatf("v%0d post acks", idx), {ic_ack, dc_ack}, 0);
        chk($sformatf("v%0d hold ic_rdata", idx), ic_rdata, v.exp_ic);
        chk($sformatf("v%0d hold dc_rdata", idx), dc_rdata, v.exp_dc);
    endtask

    // reference-model state for the randomized run
    bit            m_active, m_who, m_we, m_last, m_to;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, e_ic, e_dc;
    int            m_hi, m_gap, m_ack_next;
    bit            p_elig, p_ic, p_dc, p_we;
    logic [AW-1:0] p_ica, p_dca;
    logic [LW-1:0] p_wd;
    bit            got_ic, got_dc, was_active, gap0, new_grant;
    int            hi_cnt, ng, nic, ndc;
    bit            acked;
    logic [AW-1:0] exp_a;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h100,  '0,             3, A5S,             A5S,  '0};
        vecs[1] = '{1'b1, 1'b1, 32'h2040, 128'h1234,      0, 128'hDEAD,       A5S,  '0};
        vecs[2] = '{1'b1, 1'b0, 32'h3000, 128'h5555,      1, L77,             A5S,  L77};
        vecs[3] = '{1'b0, 1'b0, 32'h104,  '0,             TO, L012,           L012, L77};
        vecs[4] = '{1'b1, 1'b1, 32'h4000, LCAF,           2, 128'hBEEF,       L012, L77};

        do_reset();
        chk("reset mem_req", mem_req, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset acks", {ic_ack, dc_ack}, 0);
        chk("reset ic_rdata", ic_rdata, 0);
        chk("reset dc_rdata", dc_rdata, 0);
        chk("reset mem_timeout", mem_timeout, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i, 1'b0);

        // simultaneous requests straight after reset: dcache first
        do_reset();
        ic_req = 1'b1; ic_addr = 32'h500;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h600;
        mem_ready = 1'b1; mem_rdata = {4{32'h11112222}};
        tick();
        chk("tie c1 mem_req", mem_req, 1);
        chk("tie c1 mem_addr", mem_addr, 32'h600);
        tick();
        chk("tie c2 dc_ack", dc_ack, 1);
        chk("tie c2 ic_ack", ic_ack, 0);
        chk("tie c2 mem_req", mem_req, 0);
        chk("tie c2 dc_rdata", dc_rdata, {4{32'h11112222}});
        dc_req = 1'b0;
        mem_rdata = {4{32'h33334444}};
        tick();
        chk("tie c3 mem_req", mem_req, 0);
        chk("tie c3 acks", {ic_ack, dc_ack}, 0);
        tick();
        chk("tie c4 mem_req", mem_req, 1);
        chk("tie c4 mem_addr", mem_addr, 32'h500);
        tick();
        chk("tie c5 ic_ack", ic_ack, 1);
        chk("tie c5 dc_ack", dc_ack, 0);
        chk("tie c5 ic_rdata", ic_rdata, {4{32'h33334444}});
        ic_req = 1'b0;
        tick();

        // continuous contention: grants alternate DC,IC,DC,IC,...
        do_reset();
        nic = 0; ndc = 0; ng = 0;
        ic_req = 1'b1; ic_addr = 32'h1000;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h2000;
        mem_ready = 1'b1;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            tick();
            if (ic_ack) begin nic++; ic_addr = 32'h1000 + nic; end
            if (dc_ack) begin ndc++; dc_addr = 32'h2000 + ndc; end
            if (mem_req) begin
                exp_a = (ng % 2 == 0) ? 32'h2000 + ndc : 32'h1000 + nic;
                chk($sformatf("alt grant %0d addr", ng), mem_addr, exp_a);
                ng++;
            end
        end
        chk("alt grant count", ng, 6);

        // timeout with TIMEOUT=4: five cycles of mem_req, ack with zero data
        do_reset();
        run_vec('{1'b0, 1'b0, 32'h80, '0, 0, A5S, A5S, '0}, 10, 1'b0);
        ic_req = 1'b1; ic_addr = 32'h700; mem_ready = 1'b0;
        hi_cnt = 0; acked = 1'b0;
        for (int c = 0; c < 20 && !acked; c++) begin
            tick();
            if (mem_req) hi_cnt++;
            if (ic_ack) begin
                acked = 1'b1;
                chk("to ic_rdata", ic_rdata, 0);
                chk("to mem_timeout", mem_timeout, 1);
                chk("to mem_req low at ack", mem_req, 0);
            end
        end
        chk("to acked", acked, 1);
        chk("to mem_req cycles", hi_cnt, TO + 1);
        ic_req = 1'b0;
        tick();
        chk("to sticky", mem_timeout, 1);
        run_vec('{1'b1, 1'b0, 32'hA00, '0, 1, L77, '0, L77}, 11, 1'b1);
        do_reset();
        chk("to cleared by reset", mem_timeout, 0);

        // reset while a dcache access is outstanding
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h900; mem_ready = 1'b0;
        tick();
        chk("rst busy mem_req", mem_req, 1);
        reset = 1'b1;
        tick();
        chk("rst mem_req", mem_req, 0);
        chk("rst dc_ack", dc_ack, 0);
        chk("rst mem_addr", mem_addr, 0);
        reset = 1'b0; dc_req = 1'b0;
        tick();
        chk("rst after dc_ack", dc_ack, 0);
        chk("rst after mem_req", mem_req, 0);
        run_vec('{1'b0, 1'b0, 32'h800, '0, 2, L012, L012, '0}, 12, 1'b0);

        // randomized traffic against the transaction-level model
        do_reset();
        m_active = 0; m_last = 0; m_to = 0; m_gap = 0; m_ack_next = 0; m_hi = 0;
        e_ic = '0; e_dc = '0;
        p_elig = 0; p_ic = 0; p_dc = 0; p_we = 0; p_ica = '0; p_dca = '0; p_wd = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            got_ic = ic_ack;
            got_dc = dc_ack;
            chk("rnd ic_ack", ic_ack, m_ack_next == 1);
            chk("rnd dc_ack", dc_ack, m_ack_next == 2);
            chk("rnd ic_rdata", ic_rdata, e_ic);
            chk("rnd dc_rdata", dc_rdata, e_dc);
            chk("rnd mem_timeout", mem_timeout, m_to);
            m_ack_next = 0;
            was_active = m_active;
            gap0 = (m_gap == 0);
            new_grant = !m_active && p_elig && (p_ic || p_dc);
            chk("rnd mem_req", mem_req, m_active || new_grant);
            if (new_grant) begin
                m_who    = p_dc && (!p_ic || !m_last);
                m_last   = m_who;
                m_active = 1;
                m_hi     = 0;
                m_addr   = m_who ? p_dca : p_ica;
                m_we     = m_who ? p_we : 1'b0;
                m_wdata  = p_wd;
            end
            if (m_active) begin
                chk("rnd mem_addr", mem_addr, m_addr);
                chk("rnd mem_we", mem_we, m_we);
                if (m_who) chk("rnd mem_wdata", mem_wdata, m_wdata);
                m_hi++;
                if (mem_ready || m_hi == TO + 1) begin
                    m_active   = 0;
                    m_gap      = 1;
                    m_ack_next = m_who ? 2 : 1;
                    if (!mem_ready) m_to = 1;
                    if (!m_who) e_ic = mem_ready ? mem_rdata : '0;
                    else if (!m_we) e_dc = mem_ready ? mem_rdata : '0;
                end
            end
            if (!was_active && !new_grant && !gap0) m_gap--;
            p_elig = !was_active && !new_grant && gap0;
            p_ic  = ic_req;  p_dc  = dc_req;  p_we = dc_we;
            p_ica = ic_addr; p_dca = dc_addr; p_wd = dc_wdata;

            @(posedge clk);
            #1;
            if (got_ic) begin
                if ($urandom % 2 == 0) ic_addr = $urandom;
                else ic_req = 1'b0;
            end else if (!ic_req && $urandom % 4 == 0) begin
                ic_req = 1'b1;
                ic_addr = $urandom;
            end
            if (got_dc) begin
                if ($urandom % 2 == 0) begin
                    dc_addr = $urandom; dc_we = $urandom % 2;
                    dc_wdata = {$urandom, $urandom, $urandom, $urandom};
                end else dc_req = 1'b0;
            end else if (!dc_req && $urandom % 4 == 0) begin
                dc_req = 1'b1; dc_addr = $urandom; dc_we = $urandom % 2;
                dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_ready = mem_req ? ($urandom % 4 == 0) : ($urandom % 2 == 1);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single main-memory port between the instruction-cache and data-cache refill/writeback paths. Each cache presents one line-sized request and holds it until it receives a one-cycle acknowledge. The block sequences the memory handshake and alternates grants fairly when both caches miss together. It also bounds every memory transaction with a timeout, so a lost mem_ready cannot hang the pipeline stall logic.

Parameters:
ADDR_W, 32, byte-address width
LINE_W, 128, cache line width in bits
TIMEOUT, 255, max cycles mem_req may wait for mem_ready (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ic_req  in  1  icache line read request; level, held until ic_ack
ic_addr  in  ADDR_W  icache line address
ic_ack  out  1  one-cycle pulse: icache transaction complete
ic_rdata  out  LINE_W  line returned to icache; valid only with ic_ack
dc_req  in  1  dcache request; level, held until dc_ack
dc_we  in  1  1 = line writeback, 0 = line fill
dc_addr  in  ADDR_W  dcache line address
dc_wdata  in  LINE_W  writeback data
dc_ack  out  1  one-cycle pulse: dcache transaction complete
dc_rdata  out  LINE_W  line returned to dcache; valid only with dc_ack on reads
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  LINE_W  memory write data, registered
mem_ready  in  1  memory completion, sampled only while mem_req=1
mem_rdata  in  LINE_W  memory read data, valid with mem_ready
mem_timeout  out  1  sticky error flag: a transaction timed out

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, mem_req/mem_we=0, mem_addr/mem_wdata=0, ic_ack/dc_ack=0, ic_rdata/dc_rdata=0, mem_timeout=0, last_grant=IC, wait counter=0.
- States: IDLE, BUSY_IC, BUSY_DC, RESP.
- IDLE:
  - only ic_req -> BUSY_IC.
  - only dc_req -> BUSY_DC.
  - both -> grant the requester not equal to last_grant, so the first tie after reset goes to dcache.
  - On grant: latch addr, we (icache always 0) and wdata into mem_* regs; set mem_req=1; set last_grant; clear the counter.
- BUSY_x:
  - mem_req held at 1 with stable mem_addr, mem_we and mem_wdata.
  - Counter increments each cycle that mem_ready=0.
  - mem_ready=1 -> capture mem_rdata into the granted requester's rdata reg; assert its ack on the next cycle; mem_req=0; go to RESP.
  - Counter reaches TIMEOUT with mem_ready still 0 -> set mem_timeout; ack the requester anyway with rdata=0; mem_req=0; go to RESP.
  - mem_ready and the timeout in the same cycle -> mem_ready wins; no error.
- RESP: the ack pulse is high for exactly this one cycle. Requests are ignored this cycle (the requester drops req here). Next state is IDLE.
- Latency: req seen in IDLE at cycle 0 -> mem_req high cycle 1 -> mem_ready earliest cycle 1 -> ack cycle 2 -> next grant decision cycle 3. Back-to-back grant spacing is 3 cycles minimum.
- Writes: ack follows mem_ready identically; dc_rdata is not updated on writes.
- rdata outputs hold their last value between acks.
- ic_ack and dc_ack are never high in the same cycle. mem_req never stays high for more than TIMEOUT+1 cycles.
- Reset mid-transaction: everything returns to reset values next edge, and the outstanding memory access is abandoned; memory must tolerate mem_req dropping. mem_timeout is cleared only by reset.
- A request dropped before ack is a protocol violation: the transaction still completes and the ack is still issued.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, BUSY_IC, BUSY_DC, RESP), requester enum (REQ_IC, REQ_DC), default LINE_W/ADDR_W constants.
- No sub-module; the wait counter is inline, width $clog2(TIMEOUT+1).

Test Plan:
- Reset, then ic_req, ic_addr=0x100, mem_ready 3 cycles after mem_req, mem_rdata=0xA5..A5 -> mem_addr=0x100, mem_we=0, ic_ack 1 cycle later with ic_rdata=0xA5..A5, dc_ack=0 throughout.
- ic_req and dc_req asserted together right after reset, memory answers immediately -> dcache served first (mem_req cycles 1–1, dc_ack cycle 2), icache granted cycle 3, ic_ack cycle 5.
- Both requesters re-request continuously for 6 transactions -> grants strictly alternate DC,IC,DC,IC,DC,IC.
- dc_req, dc_we=1, dc_addr=0x2040, dc_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234, dc_ack after mem_ready, dc_rdata unchanged.
- TIMEOUT=4, mem_ready held 0 -> mem_req high exactly 5 cycles, then ic_ack with ic_rdata=0, mem_timeout=1 until reset.
- Reset asserted while in BUSY_DC -> next cycle mem_req=0, no dc_ack, state IDLE; a new ic_req is then granted normally.
